// File: rtl/mac_issue_ctrl.sv
// mac_issue_ctrl -- operand sequencer and result flow control for the
// 4-stage FP8 x FP8 + FP16 multiply-add pipeline.
//
// Operands arrive one byte per beat on in_data in the order A, B, C[7:0], C[15:8].
// Each assembled operation is issued to the pipeline with a single-cycle
// p_save strobe. Returning FP16 results are buffered in a small FIFO and sent
// out as two bytes, low byte first. An operation issues only when
// (inflight + fifo entries) < DEPTH, so the FIFO cannot overflow under
// normal use. ovf latches if a result still arrives while the FIFO is full.
//
// Optional build macro: MAC_ISSUE_CTRL_ACCUM_EN
//   When defined, an op whose A beat carries acc_mode=1 takes only two beats.
//   Its addend comes from an accumulator that follows every returned result.
//   That op waits until nothing is in flight.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   byte-serial operand input
//   in_fmt, acc_mode            {Bfmt, Afmt} and accumulate flag, both taken with the A beat
//   p_A, p_B, p_C, p_Afmt, p_Bfmt, p_save   pipeline issue interface
//   res_valid, res              pipeline result return
//   out_valid/out_ready/out_data  byte-serial result output
//   ovf                         sticky overflow flag
module mac_issue_ctrl #(
    parameter int LAT   = 4,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic [1:0]  in_fmt,
    input  logic        acc_mode,
    output logic [7:0]  p_A,
    output logic [7:0]  p_B,
    output logic [15:0] p_C,
    output logic        p_Afmt,
    output logic        p_Bfmt,
    output logic        p_save,
    input  logic        res_valid,
    input  logic [15:0] res,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        ovf
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // LAT only documents the pipeline depth. Flow control relies on credits.
    logic [LAT-1:0] unused_lat;
    assign unused_lat = '0;

    typedef enum logic [2:0] {LD_A, LD_B, LD_CL, LD_CH, ISSUE} state_t;
    state_t state_reg, state_next;

    logic [7:0]    a_reg, b_reg;
    logic [15:0]   c_reg;
    logic          afmt_reg, bfmt_reg;
    logic [CW-1:0] inflight_reg, count_reg;
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic          half_reg, ovf_reg;
    logic [15:0]   mem [DEPTH];

    logic          accept, acc_op, hazard_ok, credit_ok, dec, push, pop, fifo_full;
    logic [CW:0]   credit_used;
    logic [15:0]   head;

    assign accept      = in_valid & in_ready;
    assign credit_used = {1'b0, inflight_reg} + {1'b0, count_reg};
    assign credit_ok   = credit_used < (CW+1)'(DEPTH);
    assign dec         = res_valid & (inflight_reg != '0);

`ifdef MAC_ISSUE_CTRL_ACCUM_EN
    logic        acc_op_reg;
    logic [15:0] acc_reg, acc_next;
    logic        acc_load;

    assign acc_next  = res_valid ? res : acc_reg;
    assign acc_op    = acc_op_reg;
    // The accumulated addend is only final once every older result is back.
    assign hazard_ok = !acc_op_reg || (inflight_reg == '0);
    // Keep p_C tracking the accumulator from the B beat until the op issues,
    // so the value on the p_save cycle already includes a result that arrived
    // on the previous cycle.
    assign acc_load  = acc_op_reg & (((state_reg == LD_B) & accept) |
                                     ((state_reg == ISSUE) & !p_save));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg    <= '0;
            acc_op_reg <= 1'b0;
        end else begin
            acc_reg <= acc_next;
            if (accept && state_reg == LD_A)
                acc_op_reg <= acc_mode;
        end
    end
`else
    logic unused_acc_mode;
    assign unused_acc_mode = acc_mode;
    assign acc_op    = 1'b0;
    assign hazard_ok = 1'b1;
`endif

    // Input FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= LD_A;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b1;
        p_save     = 1'b0;
        case (state_reg)
            LD_A:  if (in_valid) state_next = LD_B;
            LD_B:  if (in_valid) state_next = acc_op ? ISSUE : LD_CL;
            LD_CL: if (in_valid) state_next = LD_CH;
            LD_CH: if (in_valid) state_next = ISSUE;
            ISSUE: begin
                in_ready = 1'b0;
                if (credit_ok && hazard_ok) begin
                    p_save     = 1'b1;
                    state_next = LD_A;
                end
            end
            default: state_next = LD_A;
        endcase
    end

    // Operand capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            c_reg    <= '0;
            afmt_reg <= 1'b0;
            bfmt_reg <= 1'b0;
        end else begin
            if (accept && state_reg == LD_A) begin
                a_reg    <= in_data;
                afmt_reg <= in_fmt[0];
                bfmt_reg <= in_fmt[1];
            end
            if (accept && state_reg == LD_B)
                b_reg <= in_data;
            if (accept && state_reg == LD_CL)
                c_reg[7:0] <= in_data;
            if (accept && state_reg == LD_CH)
                c_reg[15:8] <= in_data;
`ifdef MAC_ISSUE_CTRL_ACCUM_EN
            if (acc_load)
                c_reg <= acc_next;
`endif
        end
    end

    assign p_A    = a_reg;
    assign p_B    = b_reg;
    assign p_C    = c_reg;
    assign p_Afmt = afmt_reg;
    assign p_Bfmt = bfmt_reg;

    // In-flight counter. Issue is credit-limited, so it cannot exceed DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            inflight_reg <= '0;
        else if (p_save && !dec)
            inflight_reg <= inflight_reg + 1'b1;
        else if (!p_save && dec)
            inflight_reg <= inflight_reg - 1'b1;
    end

    // Result FIFO and byte serializer
    assign fifo_full = (count_reg == CW'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign pop       = out_valid & out_ready & half_reg;
    // When the FIFO is full, a pop in the same cycle frees the slot for the new result.
    assign push      = res_valid & (!fifo_full | pop);
    assign head      = mem[rd_ptr_reg];
    assign out_data  = out_valid ? (half_reg ? head[15:8] : head[7:0]) : 8'h00;
    assign ovf       = ovf_reg;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            half_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (!push && pop)
                count_reg <= count_reg - 1'b1;
            if (out_valid && out_ready)
                half_reg <= ~half_reg;
            if (res_valid && !push)
                ovf_reg <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mac_issue_ctrl.sv
module tb_mac_issue_ctrl;
    localparam int LAT   = 4;
    localparam int DEPTH = 4;
`ifdef MAC_ISSUE_CTRL_ACCUM_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic [1:0]  in_fmt = '0;
    logic        acc_mode = 1'b0;
    logic        in_ready;
    logic [7:0]  p_A, p_B;
    logic [15:0] p_C;
    logic        p_Afmt, p_Bfmt, p_save;
    logic        res_valid = 1'b0;
    logic [15:0] res = '0;
    logic        out_valid, out_ready, ovf;
    logic [7:0]  out_data;
    logic        out_ready_fix = 1'b1;
    logic        out_ready_rnd = 1'b1;
    bit          rand_rdy = 1'b0;

    assign out_ready = rand_rdy ? out_ready_rnd : out_ready_fix;

    mac_issue_ctrl #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_fmt(in_fmt), .acc_mode(acc_mode),
        .p_A(p_A), .p_B(p_B), .p_C(p_C), .p_Afmt(p_Afmt), .p_Bfmt(p_Bfmt),
        .p_save(p_save), .res_valid(res_valid), .res(res),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Pipeline model: results return lat_var cycles after p_save as p_C ^ {p_A, p_B}.
    typedef struct { int due; logic [15:0] d; } pend_t;
    pend_t pq[$];
    int          cyc = 0;
    int          lat_var = LAT;
    int          mi = 0;          // issued minus returned, floored at zero
    int          psave_cnt = 0;
    bit          saw_sim = 1'b0;
    bit          force_rv = 1'b0;
    logic [15:0] force_val = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pq.delete();
            res_valid <= 1'b0;
            res       <= '0;
            mi        <= 0;
            cyc       <= 0;
        end else begin
            if (p_save)
                pq.push_back('{due: cyc + lat_var, d: p_C ^ {p_A, p_B}});
            if (force_rv) begin
                res_valid <= 1'b1;
                res       <= force_val;
            end else if (pq.size() > 0 && pq[0].due == cyc + 1) begin
                res_valid <= 1'b1;
                res       <= pq[0].d;
                pq.pop_front();
            end else begin
                res_valid <= 1'b0;
            end
            if (p_save && res_valid && mi == 2)
                saw_sim <= 1'b1;
            mi  <= mi + (p_save ? 1 : 0) - ((res_valid && mi > 0) ? 1 : 0);
            cyc <= cyc + 1;
            if (p_save)
                psave_cnt <= psave_cnt + 1;
        end
    end

    always @(posedge clk)
        out_ready_rnd <= ($urandom_range(0, 3) != 0);

    // Reference model: assembles beats into operations, predicts the issue
    // interface and the result byte stream.
    typedef struct { logic [7:0] a, b; logic [15:0] c; logic [1:0] fmt; logic acc; } op_t;
    op_t         exp_issue[$];
    logic [7:0]  exp_out[$];
    op_t         cur, e_op;
    int          beat_cnt = 0;
    logic [15:0] last_res = '0;
    logic [15:0] ec;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_issue.delete();
            exp_out.delete();
            beat_cnt = 0;
            last_res = '0;
        end else begin
            chk("inflight", 32'(dut.inflight_reg), 32'(mi));
            if (in_valid && in_ready) begin
                case (beat_cnt)
                    0: begin
                        cur.a = in_data; cur.fmt = in_fmt; cur.acc = ACC && acc_mode;
                        cur.c = '0; beat_cnt = 1;
                    end
                    1: begin
                        cur.b = in_data;
                        if (cur.acc) begin exp_issue.push_back(cur); beat_cnt = 0; end
                        else beat_cnt = 2;
                    end
                    2: begin cur.c[7:0] = in_data; beat_cnt = 3; end
                    default: begin
                        cur.c[15:8] = in_data; exp_issue.push_back(cur); beat_cnt = 0;
                    end
                endcase
            end
            if (p_save) begin
                chk("issue_pending", 32'(exp_issue.size() > 0), 32'd1);
                if (exp_issue.size() > 0) begin
                    e_op = exp_issue.pop_front();
                    ec = e_op.acc ? last_res : e_op.c;
                    chk("p_A", 32'(p_A), 32'(e_op.a));
                    chk("p_B", 32'(p_B), 32'(e_op.b));
                    chk("p_C", 32'(p_C), 32'(ec));
                    chk("p_Afmt", 32'(p_Afmt), 32'(e_op.fmt[0]));
                    chk("p_Bfmt", 32'(p_Bfmt), 32'(e_op.fmt[1]));
                    if (e_op.acc)
                        chk("acc_wait_inflight", 32'(mi), 32'd0);
                    last_res = ec ^ {e_op.a, e_op.b};
                    exp_out.push_back(last_res[7:0]);
                    exp_out.push_back(last_res[15:8]);
                    $display("issue A=%02h B=%02h C=%04h fmt=%0d acc=%0b -> res %04h",
                             p_A, p_B, p_C, {p_Bfmt, p_Afmt}, e_op.acc, last_res);
                end
            end
            if (out_valid) begin
                chk("out_pending", 32'(exp_out.size() > 0), 32'd1);
                if (exp_out.size() > 0) begin
                    chk("out_data", 32'(out_data), 32'(exp_out[0]));
                    if (out_ready) begin
                        $display("out byte %02h", out_data);
                        void'(exp_out.pop_front());
                    end
                end
            end
        end
    end

    task automatic chk_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_p_save", 32'(p_save), 32'd0);
        chk("rst_p_A", 32'(p_A), 32'd0);
        chk("rst_p_B", 32'(p_B), 32'd0);
        chk("rst_p_C", 32'(p_C), 32'd0);
        chk("rst_p_Afmt", 32'(p_Afmt), 32'd0);
        chk("rst_p_Bfmt", 32'(p_Bfmt), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic send_beat(input logic [7:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
        chk("beat_accept", 32'(t < 200), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] c,
                           input logic [1:0] fmt, input logic acc);
        in_fmt   = fmt;
        acc_mode = acc;
        send_beat(a);
        acc_mode = 1'b0;
        send_beat(b);
        if (!acc) begin
            send_beat(c[7:0]);
            send_beat(c[15:8]);
        end
    endtask

    task automatic send_rand(input logic acc);
        send_op(8'($urandom), 8'($urandom), 16'($urandom), 2'($urandom), acc);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_issue.size() != 0 || exp_out.size() != 0 || beat_cnt != 0) && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        chk("drain", 32'(t < 2000), 32'd1);
    endtask

    int base;

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        rst_n = 1'b1;

        // 1: reset while loading C low byte, then a clean op
        send_beat(8'hAA);
        send_beat(8'hBB);
        pulse_reset();
        send_op(8'h12, 8'h34, 16'h0000, 2'b00, 1'b0);
        wait_drain();

        // 2: single op with both formats E4M3 (result 0x0438)
        send_op(8'h38, 8'h38, 16'h3C00, 2'b11, 1'b0);
        wait_drain();

        // 3: backpressure; only DEPTH ops may issue
        out_ready_fix = 1'b0;
        base = psave_cnt;
        for (int i = 0; i < 5; i++) send_rand(1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("psave_backpressure", 32'(psave_cnt - base), 32'(DEPTH));
        chk("in_ready_stalled", 32'(in_ready), 32'd0);
        chk("ovf_before_force", 32'(ovf), 32'd0);

        // 5: a result arriving into a full FIFO is dropped and sets ovf
        force_val = 16'hBEEF;
        force_rv  = 1'b1;
        @(posedge clk); #1;
        force_rv  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("out_valid_full", 32'(out_valid), 32'd1);
        out_ready_fix = 1'b1;
        send_rand(1'b0);
        wait_drain();
        chk("psave_total", 32'(psave_cnt - base), 32'd6);
        chk("ovf_sticky", 32'(ovf), 32'd1);
        pulse_reset();

        // 4: long pipeline latency so a return coincides with an issue at inflight=2
        lat_var = 10;
        for (int i = 0; i < 3; i++) send_rand(1'b0);
        wait_drain();
        chk("simultaneous_seen", 32'(saw_sim), 32'd1);
        lat_var = LAT;

`ifdef MAC_ISSUE_CTRL_ACCUM_EN
        // 6: accumulate op uses op1's result (0x1022) as its addend
        send_op(8'h11, 8'h22, 16'h0100, 2'b00, 1'b0);
        send_op(8'h01, 8'h02, 16'h0000, 2'b00, 1'b1);
        wait_drain();
`endif

        // Randomized traffic with random output backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 24; i++)
            send_rand(ACC && ($urandom_range(0, 3) == 0));
        wait_drain();
        rand_rdy = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mac_issue_ctrl.md
Name: mac_issue_ctrl

Overview:
Sequencer and flow controller for the 4-stage FP8×FP8+FP16 multiply-add pipeline. It does three jobs:
- Assembles operands arriving byte-serially on an 8-bit bus into {A, B, C, fmt}.
- Issues each assembled operation into the pipeline with a one-cycle save strobe.
- Buffers the returning FP16 results in a FIFO and streams them out as two bytes each.
A credit scheme guarantees the result FIFO can never overflow.

Parameters:
- LAT, 4, cycles from p_save to the matching res_valid (fixed pipeline depth; informational, not used for flow control).
- DEPTH, 4, result FIFO entries; also the maximum of in-flight plus buffered operations (≥2).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand byte valid.
- in_ready  out  1  controller accepts the byte this cycle.
- in_data  in  8  operand byte.
- in_fmt  in  2  {Bfmt, Afmt}, sampled with the A beat; 1 = E4M3, 0 = E5M2.
- acc_mode  in  1  sampled with the A beat; ignored unless ACCUM_EN.
- p_A  out  8  operand A to pipeline, stable while held.
- p_B  out  8  operand B.
- p_C  out  16  addend C.
- p_Afmt  out  1  A format.
- p_Bfmt  out  1  B format.
- p_save  out  1  issue strobe, one cycle per operation.
- res_valid  in  1  pipeline result valid (the final-stage saveout).
- res  in  16  FP16 result.
- out_valid  out  1  result byte valid.
- out_ready  in  1  downstream accepts the byte.
- out_data  out  8  result byte, low byte first.
- ovf  out  1  sticky error: res_valid arrived while the FIFO was full.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Outputs: in_ready=1, p_save=0, p_A/p_B/p_C/p_Afmt/p_Bfmt=0, out_valid=0, out_data=0, ovf=0.
  - State: FSM=LD_A, FIFO empty, inflight=0, acc register=0.
  - Reset mid-operation discards any partial operand and every in-flight result. Results that arrive after reset deasserts are still pushed to the FIFO; the bench must flush the pipeline with reset.
- Input FSM states: LD_A → LD_B → LD_CL → LD_CH → ISSUE → LD_A.
  - A byte is accepted on in_valid & in_ready; in_ready=1 in every LD_* state and 0 in ISSUE.
  - LD_A captures A, in_fmt and acc_mode. LD_CL captures C[7:0]. LD_CH captures C[15:8].
  - ISSUE: when inflight + fifo_count < DEPTH, assert p_save for exactly one cycle, increment inflight, and go to LD_A. Otherwise hold in ISSUE.
  - p_A/p_B/p_C/p_Afmt/p_Bfmt are registered, hold their value until the next capture, and are valid on the p_save cycle.
- Minimum throughput: 1 operation per 5 cycles. Latency from the LD_CH acceptance edge to p_save is 1 cycle when credit is available.
- inflight counter:
  - Width $clog2(DEPTH+1).
  - +1 on p_save, −1 on res_valid; both in the same cycle leave it unchanged.
  - Never wraps. A decrement at 0 is ignored.
- Result FIFO:
  - Push on res_valid. If full, the result is dropped and ovf is set, held until reset.
  - Simultaneous push and pop at full is legal; the pop frees the slot.
- Output serializer:
  - out_valid=1 whenever the FIFO is non-empty.
  - out_data = head[7:0], then head[15:8] after the low byte is accepted.
  - The entry is popped on acceptance of the high byte.
  - out_data and out_valid are held stable while out_ready=0.
- Credit accounting counts FIFO entries until they are popped. A partially transmitted entry still holds its credit.

Optional Feature:
- Macro: MAC_ISSUE_CTRL_ACCUM_EN.
- Defined:
  - When acc_mode=1 is sampled on the A beat, the FSM goes LD_A → LD_B → ISSUE, skipping the C beats. p_C is driven from a 16-bit acc register.
  - Issue of an accumulate op additionally requires inflight==0 (read-after-write hazard).
  - acc updates to res on every res_valid.
  - Results are still pushed to the FIFO.
- Undefined: acc_mode is ignored, the acc register does not exist, and every op takes 4 beats.

Test Plan:
Bench datapath model: LAT-cycle delay returning res = p_C ^ {p_A, p_B}.
1. Reset: rst_n low mid-LD_CL, with out_ready=1 throughout the test → all outputs at their reset values, FSM=LD_A; the next 4 beats 0x12,0x34,0x00,0x00 issue p_A=0x12, p_B=0x34, p_C=0x0000 → out_data bytes 0x34 then 0x12.
2. Single op: beats 0x38,0x38,0x00,0x3C with in_fmt=2'b11 → p_save pulse, p_Afmt=p_Bfmt=1, p_C=0x3C00; bytes 0x38, 0x04 appear LAT+1 or more cycles later.
3. Backpressure: out_ready=0, stream 6 operations → exactly DEPTH=4 p_save pulses, in_ready=0 stuck in ISSUE, ovf=0. Set out_ready=1 → remaining 2 issue, all 12 bytes arrive in order.
4. Simultaneous res_valid and p_save with inflight=2 → inflight stays 2.
5. Force res_valid from the model while the FIFO is full → ovf=1, FIFO contents unchanged, ovf persists until rst_n.
6. (ACCUM_EN) op1 with C=0x0100, then op2 with acc_mode=1 and only beats 0x01,0x02 → op2 p_save waits until op1's res_valid has arrived (inflight=0); op2 issues with p_C = op1's result (0x0100 ^ op1's {A, B}); op2's result = that value ^ 0x0102.
